fft_loader: RTL and testbench

Streaming front end for the FFT core. It accepts real samples over a valid/ready handshake, conditions each one to the core's bit-growth headroom, and writes it into the core's memory through the core's load port. Short frames are zero-padded. It then pulses the core's start, waits for done, holds the frame until downstream acknowledges it, and pulses the core's reset to re-arm it for the next frame.

---
 rtl/fft_loader.sv | 152 +++++++++++++++
 tb/tb_fft_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_loader.sv
// Streaming loader for the FFT core: conditions samples, loads core memory, zero-pads short frames, sequences start/done/ack.
// Optional saturating conditioning and sticky clipped flag with FFT_LOADER_SAT_EN.
module fft_loader #(
    parameter int unsigned width = 16,
    parameter int unsigned N_2   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    input  logic             in_last,
    output logic             load,
    output logic [N_2-1:0]   rd_adr,
    output logic [width-1:0] rd,
    output logic             start,
    output logic             fft_rst,
    input  logic             done,
    output logic             frame_done,
    input  logic             frame_ack,
`ifdef FFT_LOADER_SAT_EN
    output logic             clipped,
`endif
    output logic [15:0]      frame_count
);

    typedef enum logic [2:0] {
        FILL,
        PAD,
        KICK,
        BUSY,
        HOLD,
        CLR
    } state_t;

    localparam logic [N_2-1:0] LAST_ADR = {N_2{1'b1}};

    state_t             state;
    logic [N_2-1:0]     adr;
    logic               accept_c;
    logic [width-1:0]   cond_c;

    assign in_ready = (state == FILL);
    assign accept_c = in_valid & in_ready;

`ifdef FFT_LOADER_SAT_EN
    // Clamp to the signed range of width-N_2 bits, already sign-extended to width.
    localparam int unsigned SW = width - N_2;
    localparam logic [width-1:0] SAT_MAX = {{(N_2 + 1){1'b0}}, {(SW - 1){1'b1}}};
    localparam logic [width-1:0] SAT_MIN = {{(N_2 + 1){1'b1}}, {(SW - 1){1'b0}}};

    logic sat_c;

    always_comb begin
        cond_c = in_data;
        sat_c  = 1'b0;
        if ($signed(in_data) > $signed(SAT_MAX)) begin
            cond_c = SAT_MAX;
            sat_c  = 1'b1;
        end else if ($signed(in_data) < $signed(SAT_MIN)) begin
            cond_c = SAT_MIN;
            sat_c  = 1'b1;
        end
    end
`else
    assign cond_c = $signed(in_data) >>> N_2;
`endif

    // Frame sequencer; load/start/fft_rst are single-cycle registered pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            adr         <= '0;
            load        <= 1'b0;
            rd_adr      <= '0;
            rd          <= '0;
            start       <= 1'b0;
            fft_rst     <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
`ifdef FFT_LOADER_SAT_EN
            clipped     <= 1'b0;
`endif
        end else begin
            load    <= 1'b0;
            start   <= 1'b0;
            fft_rst <= 1'b0;
            case (state)
                FILL: begin
                    if (accept_c) begin
                        load   <= 1'b1;
                        rd_adr <= adr;
                        rd     <= cond_c;
`ifdef FFT_LOADER_SAT_EN
                        if (sat_c) begin
                            clipped <= 1'b1;
                        end
`endif
                        // in_last on the final address is irrelevant: the frame is full anyway.
                        if (adr == LAST_ADR) begin
                            state <= KICK;
                        end else begin
                            adr <= adr + N_2'(1);
                            if (in_last) begin
                                state <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    load   <= 1'b1;
                    rd_adr <= adr;
                    rd     <= '0;
                    if (adr == LAST_ADR) begin
                        state <= KICK;
                    end else begin
                        adr <= adr + N_2'(1);
                    end
                end
                KICK: begin
                    start <= 1'b1;
                    state <= BUSY;
                end
                BUSY: begin
                    if (done) begin
                        state       <= HOLD;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end
                end
                HOLD: begin
                    if (frame_ack) begin
                        state      <= CLR;
                        frame_done <= 1'b0;
                        fft_rst    <= 1'b1;
                        adr        <= '0;
`ifdef FFT_LOADER_SAT_EN
                        clipped    <= 1'b0;
`endif
                    end
                end
                CLR: begin
                    state <= FILL;
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_loader.sv
// Self-checking bench for fft_loader: random frames checked against a cycle-timeline reference model.
module tb_fft_loader;

    localparam int W  = 16;
    localparam int NB = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          load;
    logic [NB-1:0] rd_adr;
    logic [W-1:0]  rd;
    logic          start;
    logic          fft_rst;
    logic          done = 1'b0;
    logic          frame_done;
    logic          frame_ack = 1'b0;
    logic [15:0]   frame_count;
`ifdef FFT_LOADER_SAT_EN
    logic          clipped;
`endif

    fft_loader #(.width(W), .N_2(NB)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .load(load),
        .rd_adr(rd_adr),
        .rd(rd),
        .start(start),
        .fft_rst(fft_rst),
        .done(done),
        .frame_done(frame_done),
        .frame_ack(frame_ack),
`ifdef FFT_LOADER_SAT_EN
        .clipped(clipped),
`endif
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: a timeline of expected events keyed by cycle number.
    bit          exp_ready;
    bit          exp_fdone;
    bit          exp_clip;
    logic [15:0] exp_count;
    int          nacc;
    int          start_cyc;
    int          rise_cyc;
    int          clr_cyc;
    int          ld_adr[int];
    logic [15:0] ld_dat[int];
    bit          clip_at[int];
    logic [15:0] fdata[N];

    function automatic logic [15:0] ref_cond(input logic [15:0] x);
        int v;
        int r;
        v = int'($signed(x));
`ifdef FFT_LOADER_SAT_EN
        begin
            int lim;
            lim = 1 << (W - NB - 1);
            if (v > lim - 1)   r = lim - 1;
            else if (v < -lim) r = -lim;
            else               r = v;
        end
`else
        begin
            int d;
            d = 1 << NB;
            r = (v - (((v % d) + d) % d)) / d;
        end
`endif
        return 16'(r);
    endfunction

    function automatic bit ref_clips(input logic [15:0] x);
`ifdef FFT_LOADER_SAT_EN
        int v;
        int lim;
        v = int'($signed(x));
        lim = 1 << (W - NB - 1);
        return (v > lim - 1) || (v < -lim);
`else
        return x === 16'hxxxx;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_clear();
        exp_ready = 1'b1;
        exp_fdone = 1'b0;
        exp_clip  = 1'b0;
        exp_count = 16'd0;
        nacc      = 0;
        start_cyc = -1;
        rise_cyc  = -1;
        clr_cyc   = -1;
        ld_adr.delete();
        ld_dat.delete();
        clip_at.delete();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        done      = 1'b0;
        frame_ack = 1'b0;
        reset     = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_rd_adr", 32'(rd_adr), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_fft_rst", 32'(fft_rst), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
`ifdef FFT_LOADER_SAT_EN
        chk("rst_clipped", 32'(clipped), 32'd0);
`endif
        tick();
        tick();
        chk("rst_hold_start", 32'(start), 32'd0);
        chk("rst_hold_fft_rst", 32'(fft_rst), 32'd0);
        reset = 1'b0;
        model_clear();
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check every output.
    task automatic run_cycle(input bit v, input logic [15:0] d, input bit l, input bit dn, input bit ak);
        bit fin;
        fin = 1'b0;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        done      = dn;
        frame_ack = ak;
        if (v && exp_ready) begin
            ld_adr[cyc + 1] = nacc;
            ld_dat[cyc + 1] = ref_cond(d);
            if (ref_clips(d)) clip_at[cyc + 1] = 1'b1;
            nacc++;
            if (nacc == N) begin
                fin = 1'b1;
                start_cyc = cyc + 2;
            end else if (l) begin
                fin = 1'b1;
                for (int a = nacc; a < N; a++) begin
                    ld_adr[cyc + 2 + a - nacc] = a;
                    ld_dat[cyc + 2 + a - nacc] = 16'h0000;
                end
                start_cyc = cyc + 2 + (N - nacc);
            end
        end
        if (dn && start_cyc >= 0 && cyc >= start_cyc && rise_cyc < 0) rise_cyc = cyc + 1;
        if (ak && rise_cyc >= 0 && cyc >= rise_cyc && clr_cyc < 0) clr_cyc = cyc + 1;
        tick();
        if (fin) exp_ready = 1'b0;
        if (clip_at.exists(cyc)) exp_clip = 1'b1;
        if (cyc == rise_cyc) begin
            exp_fdone = 1'b1;
            exp_count = exp_count + 16'd1;
        end
        if (cyc == clr_cyc) begin
            exp_fdone = 1'b0;
            exp_clip  = 1'b0;
        end
        if (clr_cyc >= 0 && cyc == clr_cyc + 1) begin
            exp_ready = 1'b1;
            nacc      = 0;
            start_cyc = -1;
            rise_cyc  = -1;
            clr_cyc   = -1;
        end
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("load", 32'(load), 32'(ld_adr.exists(cyc)));
        if (ld_adr.exists(cyc)) begin
            chk("rd_adr", 32'(rd_adr), 32'(ld_adr[cyc]));
            chk("rd", 32'(rd), 32'(ld_dat[cyc]));
        end
        chk("start", 32'(start), 32'(cyc == start_cyc));
        chk("fft_rst", 32'(fft_rst), 32'(cyc == clr_cyc));
        chk("frame_done", 32'(frame_done), 32'(exp_fdone));
        chk("frame_count", 32'(frame_count), 32'(exp_count));
`ifdef FFT_LOADER_SAT_EN
        chk("clipped", 32'(clipped), 32'(exp_clip));
`endif
    endtask

    // One complete frame of k samples from fdata, through done and frame_ack.
    task automatic run_frame(input int k, input bit last_flag, input int gap_pct,
                             input bit hold_valid, input bit spur);
        int i;
        int guard;
        int dly;
        bit v;
        bit acc;
        i = 0;
        guard = 0;
        while (i < k && guard < 2000) begin
            v   = ($urandom_range(99) >= 32'(gap_pct));
            acc = v && exp_ready;
            run_cycle(v, v ? fdata[i] : 16'($urandom), last_flag && (i == k - 1),
                      spur && ($urandom_range(3) == 0), 1'b0);
            if (acc) i++;
            guard++;
        end
        chk("frame_fill_bound", 32'(i), 32'(k));
        dly = $urandom_range(5);
        guard = 0;
        while ((start_cyc < 0 || cyc < start_cyc + dly) && guard < 300) begin
            run_cycle(hold_valid, 16'($urandom), 1'b0, 1'b0,
                      spur && start_cyc >= 0 && cyc >= start_cyc);
            guard++;
        end
        chk("start_wait_bound", 32'(guard < 300), 32'd1);
        run_cycle(hold_valid, 16'($urandom), 1'b0, 1'b1, 1'b0);
        dly = $urandom_range(4);
        for (int j = 0; j < dly; j++) begin
            run_cycle(hold_valid, 16'($urandom), 1'b0, spur, 1'b0);
        end
        run_cycle(hold_valid, 16'($urandom), 1'b0, 1'b0, 1'b1);
        run_cycle(hold_valid, 16'($urandom), 1'b0, 1'b0, 1'b0);
        chk("ready_after_ack", 32'(in_ready), 32'd1);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            fdata[i] = ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom_range(2047) - 1024);
        end
    endtask

    initial begin
        int k;
        model_clear();
        do_reset();

        // Full frame of 0x0400 with in_valid held high, backpressure through BUSY/HOLD.
        for (int i = 0; i < N; i++) fdata[i] = 16'h0400;
        run_frame(N, 1'b0, 0, 1'b1, 1'b1);
        chk("count_after_first", 32'(frame_count), 32'd1);

        // Short frame of 5 samples, spurious done during fill.
        rand_data();
        run_frame(5, 1'b1, 30, 1'b0, 1'b1);

        // Saturation corner values.
        fdata[0] = 16'h7FFF;
        fdata[1] = 16'h8000;
        fdata[2] = 16'h0123;
        run_frame(3, 1'b1, 0, 1'b0, 1'b0);

        // in_last on sample N-2 (one pad) and on sample N-1 (ignored).
        rand_data();
        run_frame(N - 1, 1'b1, 20, 1'b1, 1'b0);
        rand_data();
        run_frame(N, 1'b1, 10, 1'b0, 1'b1);
        rand_data();
        run_frame(1, 1'b1, 0, 1'b1, 1'b0);

        // Reset mid-fill after 10 samples, then a fresh frame starting at address 0.
        rand_data();
        for (int i = 0; i < 10; i++) run_cycle(1'b1, fdata[i], 1'b0, 1'b0, 1'b0);
        do_reset();
        rand_data();
        run_frame(N, 1'b0, 25, 1'b0, 1'b0);
        chk("count_after_reset", 32'(frame_count), 32'd1);

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            rand_data();
            k = $urandom_range(N, 1);
            run_frame(k, (k < N) ? 1'b1 : 1'($urandom_range(1)), $urandom_range(50),
                      1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
